q_flop_stage: RTL and testbench
===============================

# q_flop_stage

Clocked, single-token two-phase handshake pipeline stage modelled on the Q-flop micropipeline element. Each stage accepts a request transition from its predecessor, holds one token, and forwards a request transition to its successor. It releases the token when the successor acknowledges. Stages chain head-to-tail into linear FIFOs or rings: a stage's `so` drives the next stage's `pi`, and the next stage's `po` drives this stage's `si`.

## Interface
Parameters:
- `SYNC_STAGES`, default 0. Number of flip-flops that resynchronise `pi` and `si` before use. Allowed values: 0 (direct) or 2–3.

Ports:
- `clk`, in, 1. Single clock; all state changes on the rising edge.
- `rst`, in, 1. Reset, synchronous and active-high. It has priority over everything else.
- `start`, in, 1. Synchronous initialise/hold. While high, the stage performs no handshakes and its state is frozen.
- `pi`, in, 1. Request from the predecessor (two-phase: a new request is any value where `pi != po`).
- `si`, in, 1. Acknowledge from the successor (two-phase: acknowledged when `si == so`).
- `po`, out, 1. Acknowledge to the predecessor. Registered.
- `so`, out, 1. Request to the successor. Registered.
- `f`, out, 1. Full flag: the stage holds an unacknowledged token. Registered.

## Operation
- Internal names: `pi_s` and `si_s` are `pi` and `si` after `SYNC_STAGES` flops, or the raw inputs when the parameter is 0.
- Derived conditions:
  - `req = (pi_s != po)`
  - `ack = f & (si_s == so)`
  - `can_take = ~f | ack`
- Priority on each rising edge:
  - `rst=1` → `po=0`, `so=0`, `f=0`, and synchroniser flops cleared to 0.
  - else `start=1` → all state held.
  - else if `req & can_take` (accept) → `po <= pi_s`, `so <= ~so`, `f <= 1`.
  - else if `ack` (drain) → `f <= 0`; `po` and `so` unchanged.
  - else hold.
- Simultaneous accept and drain: the accept wins. The old token retires and the new one is forwarded in the same cycle, so `f` stays 1 and `so` toggles again.
- Exactly one token per stage; the stage never overwrites an unacknowledged token.
- Reset mid-transfer discards the token. Peers must be reset in the same cycle to keep phases consistent.

## Timing
- Request to forward latency is 1 cycle (plus `SYNC_STAGES`): edge N sees `req`, and `po` and `so` toggle at edge N+1.
- Acknowledge to empty is 1 cycle (plus `SYNC_STAGES`).
- Sustained throughput is 1 token/cycle when `SYNC_STAGES=0` and the successor acknowledges combinationally.
- In a ring where the head has `pi = ~po` and the tail has `si = so`, every stage toggles `so` once per token with no deadlock.
- Outputs are glitch-free, driven directly from flops.

## Structure
- No shared package needed. The only constant is the reset phase value 0; keep it local.
- One sub-module: `q_sync`, a parameterised N-flop synchronizer with synchronous reset, instantiated twice (for `pi` and `si`). When N=0 it is a pass-through.

## Test plan
- Reset: hold `rst=1` with `start=1` for 2 cycles, then `start=0` for 2 cycles → `po=0`, `so=0`, `f=0` throughout; no toggles after release while `pi=0`, `si=0`.
- Single token: drive `pi=1` with `si=0` → next edge `po=1`, `so=1`, `f=1`. Then drive `si=1` → next edge `f=0`, with `po` and `so` still 1.
- Backpressure: with `f=1` and `si != so`, toggle `pi` → `po`, `so` and `f` unchanged until `si` matches `so`; the accept then happens in that same cycle, with `f` staying 1 and `so` toggling.
- Start freeze: while `start=1` after reset, toggle `pi` → no output change. Drop `start` → accept on the next edge.
- Five-stage ring: chain 5 stages, head `pi1 = ~po1`, tail `si5 = so5`, `SYNC_STAGES=0`. Run 50 cycles after reset → each `so_k` toggles, no stage stalls permanently, and the count of `so5` toggles is at least 10.
- `SYNC_STAGES=2`: repeat the single-token test → `po`/`so` toggle 3 cycles after `pi` changes.

Source files
------------

// File: rtl/q_sync.sv
// N-flop input resynchroniser with synchronous reset; N=0 is a plain wire.
// Used in front of the two-phase handshake inputs of q_flop_stage.
module q_sync #(
    parameter int N = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (N == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_ff
            logic [N-1:0] ff;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ff <= '0;
                end else begin
                    ff[0] <= d;
                    for (int i = 1; i < N; i++) begin
                        ff[i] <= ff[i-1];
                    end
                end
            end

            assign q = ff[N-1];
        end
    endgenerate

endmodule

// File: rtl/q_flop_stage.sv
// Single-token two-phase micropipeline stage (clocked Q-flop element).
// Chains head-to-tail: so -> next pi, next po -> si.
module q_flop_stage #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pi,
    input  logic si,
    output logic po,
    output logic so,
    output logic f
);

    localparam logic PHASE_RST = 1'b0;

    generate
        if (!(SYNC_STAGES == 0 || SYNC_STAGES == 2 || SYNC_STAGES == 3)) begin : g_bad_param
            $error("q_flop_stage: SYNC_STAGES must be 0, 2 or 3");
        end
    endgenerate

    logic pi_s;
    logic si_s;
    logic req;
    logic ack;
    logic can_take;

    // The synchronisers keep sampling while start is high so that the
    // resynchronised view of the peers is current when start drops.
    q_sync #(.N(SYNC_STAGES)) u_sync_pi (
        .clk (clk),
        .rst (rst),
        .d   (pi),
        .q   (pi_s)
    );

    q_sync #(.N(SYNC_STAGES)) u_sync_si (
        .clk (clk),
        .rst (rst),
        .d   (si),
        .q   (si_s)
    );

    assign req      = (pi_s != po);
    assign ack      = f & (si_s == so);
    assign can_take = ~f | ack;

    // Accept outranks drain: a retiring token is replaced in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            po <= PHASE_RST;
            so <= PHASE_RST;
            f  <= 1'b0;
        end else if (!start) begin
            if (req && can_take) begin
                po <= pi_s;
                so <= ~so;
                f  <= 1'b1;
            end else if (ack) begin
                f  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_q_flop_stage.sv
// Bench for q_flop_stage: directed scenarios, randomized traffic against a
// token-counting reference, SYNC_STAGES=2 latency, and a five-stage ring.
module tb_q_flop_stage;

    logic clk;
    logic rst;
    logic start;
    logic pi;
    logic si;
    logic po_a, so_a, f_a;
    logic po_b, so_b, f_b;

    logic       ring_rst;
    logic       ring_start;
    logic [4:0] r_pi, r_si, r_po, r_so, r_f;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: a stage is described by how many tokens it has forwarded
    // (the phase of po/so is the parity of that count) and whether the most
    // recently forwarded token is still waiting for its acknowledge.
    typedef struct {
        int fwd;
        bit holding;
    } mstate_t;

    mstate_t ma, mb;
    bit pd[2];
    bit sd[2];

    function automatic mstate_t model_next(mstate_t m, bit r, bit st, bit p, bit s);
        mstate_t n;
        bit phase;
        bit want_in;
        bit acked;
        n = m;
        if (r) begin
            n.fwd = 0;
            n.holding = 0;
        end else if (!st) begin
            phase   = bit'(m.fwd % 2);
            want_in = (p != phase);
            acked   = m.holding && (s == phase);
            if (want_in && (!m.holding || acked)) begin
                n.fwd = m.fwd + 1;
                n.holding = 1;
            end else if (acked) begin
                n.holding = 0;
            end
        end
        return n;
    endfunction

    function automatic logic [2:0] model_out(mstate_t m);
        bit ph;
        ph = bit'(m.fwd % 2);
        return {ph, ph, m.holding};
    endfunction

    q_flop_stage #(.SYNC_STAGES(0)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .pi    (pi),
        .si    (si),
        .po    (po_a),
        .so    (so_a),
        .f     (f_a)
    );

    q_flop_stage #(.SYNC_STAGES(2)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .pi    (pi),
        .si    (si),
        .po    (po_b),
        .so    (so_b),
        .f     (f_b)
    );

    assign r_pi[0] = ~r_po[0];
    assign r_si[4] = r_so[4];

    genvar gk;
    generate
        for (gk = 1; gk < 5; gk++) begin : g_fwd
            assign r_pi[gk] = r_so[gk-1];
        end
        for (gk = 0; gk < 4; gk++) begin : g_bwd
            assign r_si[gk] = r_po[gk+1];
        end
        for (gk = 0; gk < 5; gk++) begin : g_ring
            q_flop_stage #(.SYNC_STAGES(0)) u_stage (
                .clk   (clk),
                .rst   (ring_rst),
                .start (ring_start),
                .pi    (r_pi[gk]),
                .si    (r_si[gk]),
                .po    (r_po[gk]),
                .so    (r_so[gk]),
                .f     (r_f[gk])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance both references by one edge using the inputs currently driven,
    // then let the DUTs take that edge and settle.
    task automatic step();
        ma = model_next(ma, rst, start, pi, si);
        mb = model_next(mb, rst, start, pd[1], sd[1]);
        if (rst) begin
            pd[0] = 0; pd[1] = 0;
            sd[0] = 0; sd[1] = 0;
        end else begin
            pd[1] = pd[0]; pd[0] = pi;
            sd[1] = sd[0]; sd[0] = si;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; start = 1; pi = 0; si = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) start = 0;
            step();
            n_cmp++;
            if ({po_a, so_a, f_a} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_a[%0d]: {po,so,f} got %b want 000", i, {po_a, so_a, f_a});
            end
            n_cmp++;
            if ({po_b, so_b, f_b} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_b[%0d]: {po,so,f} got %b want 000", i, {po_b, so_b, f_b});
            end
        end
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({po_a, so_a, f_a, po_b, so_b, f_b} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: a=%b b=%b want 000/000", i,
                         {po_a, so_a, f_a}, {po_b, so_b, f_b});
            end
        end
    endtask

    task automatic test_single_token();
        pi = 1; si = 0;
        step();
        n_cmp++;
        if ({po_a, so_a, f_a} !== 3'b111) begin
            n_err++;
            $display("FAIL single_accept: {po,so,f} got %b want 111", {po_a, so_a, f_a});
        end
        si = 1;
        step();
        n_cmp++;
        if ({po_a, so_a, f_a} !== 3'b110) begin
            n_err++;
            $display("FAIL single_drain: {po,so,f} got %b want 110", {po_a, so_a, f_a});
        end
    endtask

    task automatic test_backpressure();
        pi = 0;
        step();
        n_cmp++;
        if ({po_a, so_a, f_a} !== 3'b001) begin
            n_err++;
            $display("FAIL bp_accept: {po,so,f} got %b want 001", {po_a, so_a, f_a});
        end
        pi = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({po_a, so_a, f_a} !== 3'b001) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: {po,so,f} got %b want 001", i, {po_a, so_a, f_a});
            end
        end
        si = 0;
        step();
        n_cmp++;
        if ({po_a, so_a, f_a} !== 3'b111) begin
            n_err++;
            $display("FAIL bp_accept_and_drain: {po,so,f} got %b want 111", {po_a, so_a, f_a});
        end
    endtask

    task automatic test_start_freeze();
        rst = 1; start = 1; pi = 0; si = 0;
        step();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            pi = ~pi;
            step();
            n_cmp++;
            if ({po_a, so_a, f_a} !== 3'b000) begin
                n_err++;
                $display("FAIL start_frozen[%0d]: {po,so,f} got %b want 000", i, {po_a, so_a, f_a});
            end
        end
        pi = 1;
        step();
        n_cmp++;
        if ({po_a, so_a, f_a} !== 3'b000) begin
            n_err++;
            $display("FAIL start_frozen_last: {po,so,f} got %b want 000", {po_a, so_a, f_a});
        end
        start = 0;
        step();
        n_cmp++;
        if ({po_a, so_a, f_a} !== 3'b111) begin
            n_err++;
            $display("FAIL start_release: {po,so,f} got %b want 111", {po_a, so_a, f_a});
        end
    endtask

    task automatic test_sync2();
        logic [2:0] want_b [3];
        rst = 1; start = 0; pi = 0; si = 0;
        step();
        rst = 0;
        step();
        step();
        pi = 1;
        want_b = '{3'b000, 3'b000, 3'b111};
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({po_b, so_b, f_b} !== want_b[i]) begin
                n_err++;
                $display("FAIL sync2_req[%0d]: {po,so,f} got %b want %b", i, {po_b, so_b, f_b}, want_b[i]);
            end
        end
        si = 1;
        want_b = '{3'b111, 3'b111, 3'b110};
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({po_b, so_b, f_b} !== want_b[i]) begin
                n_err++;
                $display("FAIL sync2_ack[%0d]: {po,so,f} got %b want %b", i, {po_b, so_b, f_b}, want_b[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] exp_a;
        logic [2:0] exp_b;
        rst = 1; start = 0; pi = 0; si = 0;
        step();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(31) == 0);
            start = ($urandom_range(7) == 0);
            pi    = 1'($urandom_range(1));
            si    = 1'($urandom_range(1));
            step();
            exp_a = model_out(ma);
            exp_b = model_out(mb);
            n_cmp++;
            if ({po_a, so_a, f_a} !== exp_a) begin
                n_err++;
                $display("FAIL rand_a[%0d]: {po,so,f} got %b want %b", i, {po_a, so_a, f_a}, exp_a);
            end
            n_cmp++;
            if ({po_b, so_b, f_b} !== exp_b) begin
                n_err++;
                $display("FAIL rand_b[%0d]: {po,so,f} got %b want %b", i, {po_b, so_b, f_b}, exp_b);
            end
        end
        rst = 0; start = 0;
    endtask

    task automatic test_ring();
        int         toggles [5];
        int         last_tog [5];
        logic [4:0] prev;
        ring_rst = 1;
        step();
        step();
        ring_rst = 0;
        prev = r_so;
        for (int k = 0; k < 5; k++) begin
            toggles[k] = 0;
            last_tog[k] = -1;
        end
        for (int c = 0; c < 50; c++) begin
            step();
            for (int k = 0; k < 5; k++) begin
                if (r_so[k] != prev[k]) begin
                    toggles[k]++;
                    last_tog[k] = c;
                end
            end
            prev = r_so;
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (toggles[k] < 1) begin
                n_err++;
                $display("FAIL ring_toggle[%0d]: toggles got %0d want >=1", k, toggles[k]);
            end
            n_cmp++;
            if (last_tog[k] < 40) begin
                n_err++;
                $display("FAIL ring_stall[%0d]: last toggle cycle got %0d want >=40", k, last_tog[k]);
            end
        end
        n_cmp++;
        if (toggles[4] < 10) begin
            n_err++;
            $display("FAIL ring_tail_rate: so5 toggles got %0d want >=10", toggles[4]);
        end
    endtask

    initial begin
        rst = 1; start = 1; pi = 0; si = 0;
        ring_rst = 1; ring_start = 0;
        ma = '{fwd: 0, holding: 0};
        mb = '{fwd: 0, holding: 0};
        pd[0] = 0; pd[1] = 0;
        sd[0] = 0; sd[1] = 0;

        test_reset();
        test_single_token();
        test_backpressure();
        test_start_freeze();
        test_sync2();
        test_random();
        test_ring();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
